// File: rtl/battleship_pkg.sv
// Shared types and constants for the Battleship firing-phase logic.
package battleship_pkg;

    localparam int BOARD_N_DEF = 5;
    localparam int MAX_SHIPS   = 5;

    typedef enum logic [1:0] {
        WATER = 2'b00,
        SHIP  = 2'b01,
        MISS  = 2'b10,
        HIT   = 2'b11
    } cell_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_P_WAIT,
        S_P_CHECK,
        S_P_WRITE,
        S_PC_WAIT,
        S_PC_PICK,
        S_PC_CHECK,
        S_PC_WRITE,
        S_WIN,
        S_LOSE
    } seq_state_t;

    function automatic logic [2:0] clamp_ships(input logic [2:0] n);
        return (n > 3'(MAX_SHIPS)) ? 3'(MAX_SHIPS) : n;
    endfunction

endpackage

// File: rtl/pc_target_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) that supplies PC target candidates.
module pc_target_lfsr (
    input  logic       clk,
    input  logic       rst,
    input  logic       step_i,
    input  logic [7:0] seed_i,
    output logic [7:0] q_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (step_i) begin
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= seed_i;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q_o = lfsr_q;

endmodule

// File: rtl/turn_sequencer.sv
// Battleship firing-phase sequencer: alternates player/PC shots on two 5x5 boards.
// Optional player-turn timeout is compiled in when TURN_TIMEOUT_EN is defined.
module turn_sequencer
    import battleship_pkg::*;
#(
    parameter int         BOARD_N    = BOARD_N_DEF,
    parameter int         PC_DELAY   = 25_000_000,
    parameter logic [7:0] LFSR_SEED  = 8'hA5,
    parameter int         PL_TIMEOUT = 500_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [2:0] ship_count_i,
    input  logic       fire_i,
    input  logic [2:0] cur_i_i,
    input  logic [2:0] cur_j_i,
    output logic [2:0] pc_i_o,
    output logic [2:0] pc_j_o,
    input  logic [1:0] pc_rd_data_i,
    output logic       pc_wr_en_o,
    output logic [1:0] pc_wr_data_o,
    output logic [2:0] pl_i_o,
    output logic [2:0] pl_j_o,
    input  logic [1:0] pl_rd_data_i,
    output logic       pl_wr_en_o,
    output logic [1:0] pl_wr_data_o,
    output logic       turn_o,
    output logic       shot_valid_o,
    output logic       shot_hit_o,
    output logic [2:0] player_hits_o,
    output logic [2:0] pc_hits_o,
    output logic       victory_o,
    output logic       defeat_o
);

    localparam logic [3:0] BN       = 4'(BOARD_N);
    localparam int         DLY_W    = (PC_DELAY > 1) ? $clog2(PC_DELAY) : 1;
    localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(PC_DELAY - 1);

    seq_state_t       state_q, state_d;
    logic [2:0]       pc_i_q, pc_i_d, pc_j_q, pc_j_d;
    logic [2:0]       pl_i_q, pl_i_d, pl_j_q, pl_j_d;
    logic             hit_q, hit_d;
    logic [2:0]       target_q, target_d;
    logic [2:0]       player_hits_q, player_hits_d;
    logic [2:0]       pc_hits_q, pc_hits_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [2:0]       hits_next;
    logic             lfsr_step;
    logic [7:0]       lfsr_q;
    logic             timeout_hit;

    pc_target_lfsr u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .step_i (lfsr_step),
        .seed_i (LFSR_SEED),
        .q_o    (lfsr_q)
    );

`ifdef TURN_TIMEOUT_EN
    localparam int TO_W = (PL_TIMEOUT > 1) ? $clog2(PL_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(PL_TIMEOUT - 1);

    logic [TO_W-1:0] to_q, to_d;

    // Reload on every entry to P_WAIT, count down only while waiting there.
    always_comb begin
        to_d = to_q;
        if (state_d == S_P_WAIT && state_q != S_P_WAIT) begin
            to_d = TO_LOAD;
        end else if (state_q == S_P_WAIT && to_q != '0) begin
            to_d = to_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_q <= '0;
        end else begin
            to_q <= to_d;
        end
    end

    assign timeout_hit = (to_q == '0);
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        pc_i_d        = pc_i_q;
        pc_j_d        = pc_j_q;
        pl_i_d        = pl_i_q;
        pl_j_d        = pl_j_q;
        hit_d         = hit_q;
        target_d      = target_q;
        player_hits_d = player_hits_q;
        pc_hits_d     = pc_hits_q;
        dly_d         = dly_q;
        hits_next     = '0;
        lfsr_step     = 1'b0;
        pl_i_o        = pl_i_q;
        pl_j_o        = pl_j_q;
        pc_wr_en_o    = 1'b0;
        pc_wr_data_o  = WATER;
        pl_wr_en_o    = 1'b0;
        pl_wr_data_o  = WATER;
        turn_o        = 1'b0;
        shot_valid_o  = 1'b0;
        shot_hit_o    = 1'b0;
        victory_o     = 1'b0;
        defeat_o      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i && ship_count_i != 3'd0) begin
                    target_d = clamp_ships(ship_count_i);
                    state_d  = S_P_WAIT;
                end
            end
            S_P_WAIT: begin
                if (fire_i && ({1'b0, cur_i_i} < BN) && ({1'b0, cur_j_i} < BN)) begin
                    pc_i_d  = cur_i_i;
                    pc_j_d  = cur_j_i;
                    state_d = S_P_CHECK;
                end else if (timeout_hit) begin
                    dly_d   = DLY_LOAD;
                    state_d = S_PC_WAIT;
                end
            end
            S_P_CHECK: begin
                if (pc_rd_data_i[1]) begin
                    state_d = S_P_WAIT;
                end else begin
                    hit_d   = (pc_rd_data_i == SHIP);
                    state_d = S_P_WRITE;
                end
            end
            S_P_WRITE: begin
                pc_wr_en_o   = 1'b1;
                pc_wr_data_o = hit_q ? HIT : MISS;
                shot_valid_o = 1'b1;
                shot_hit_o   = hit_q;
                hits_next    = (hit_q && player_hits_q != target_q) ? player_hits_q + 3'd1
                                                                    : player_hits_q;
                player_hits_d = hits_next;
                if (hits_next == target_q) begin
                    state_d = S_WIN;
                end else begin
                    dly_d   = DLY_LOAD;
                    state_d = S_PC_WAIT;
                end
            end
            S_PC_WAIT: begin
                turn_o = 1'b1;
                if (dly_q == '0) begin
                    state_d = S_PC_PICK;
                end else begin
                    dly_d = dly_q - 1'b1;
                end
            end
            S_PC_PICK: begin
                // Candidate is presented on the player-board address so its cell can be vetted this cycle.
                turn_o    = 1'b1;
                lfsr_step = 1'b1;
                pl_i_o    = lfsr_q[5:3];
                pl_j_o    = lfsr_q[2:0];
                if (({1'b0, lfsr_q[5:3]} < BN) && ({1'b0, lfsr_q[2:0]} < BN) && !pl_rd_data_i[1]) begin
                    pl_i_d  = lfsr_q[5:3];
                    pl_j_d  = lfsr_q[2:0];
                    state_d = S_PC_CHECK;
                end
            end
            S_PC_CHECK: begin
                turn_o = 1'b1;
                if (pl_rd_data_i[1]) begin
                    state_d = S_PC_PICK;
                end else begin
                    hit_d   = (pl_rd_data_i == SHIP);
                    state_d = S_PC_WRITE;
                end
            end
            S_PC_WRITE: begin
                turn_o       = 1'b1;
                pl_wr_en_o   = 1'b1;
                pl_wr_data_o = hit_q ? HIT : MISS;
                shot_valid_o = 1'b1;
                shot_hit_o   = hit_q;
                hits_next    = (hit_q && pc_hits_q != target_q) ? pc_hits_q + 3'd1 : pc_hits_q;
                pc_hits_d    = hits_next;
                state_d      = (hits_next == target_q) ? S_LOSE : S_P_WAIT;
            end
            S_WIN: begin
                victory_o = 1'b1;
            end
            S_LOSE: begin
                defeat_o = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_i_q        <= '0;
            pc_j_q        <= '0;
            pl_i_q        <= '0;
            pl_j_q        <= '0;
            hit_q         <= 1'b0;
            target_q      <= '0;
            player_hits_q <= '0;
            pc_hits_q     <= '0;
            dly_q         <= '0;
        end else begin
            state_q       <= state_d;
            pc_i_q        <= pc_i_d;
            pc_j_q        <= pc_j_d;
            pl_i_q        <= pl_i_d;
            pl_j_q        <= pl_j_d;
            hit_q         <= hit_d;
            target_q      <= target_d;
            player_hits_q <= player_hits_d;
            pc_hits_q     <= pc_hits_d;
            dly_q         <= dly_d;
        end
    end

    assign pc_i_o        = pc_i_q;
    assign pc_j_o        = pc_j_q;
    assign player_hits_o = player_hits_q;
    assign pc_hits_o     = pc_hits_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed self-checking bench for turn_sequencer with behavioural 8x8 board models.
module tb_turn_sequencer;
    import battleship_pkg::*;

    localparam int PC_DELAY   = 4;
    localparam int PL_TIMEOUT = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [2:0] ship_count = '0;
    logic       fire = 1'b0;
    logic [2:0] cur_i = '0, cur_j = '0;
    logic [2:0] pc_i, pc_j, pl_i, pl_j;
    logic [1:0] pc_rd_data, pl_rd_data, pc_wr_data, pl_wr_data;
    logic       pc_wr_en, pl_wr_en, turn, shot_valid, shot_hit, victory, defeat;
    logic [2:0] player_hits, pc_hits;

    logic [1:0] pc_board [8][8];
    logic [1:0] pl_board [8][8];
    int         pc_wr_cnt = 0;
    int         pl_wr_cnt = 0;
    int         both_wr   = 0;
    logic [2:0] last_pl_i = '0, last_pl_j = '0;
    logic [1:0] last_pl_prev = '0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    turn_sequencer #(
        .PC_DELAY   (PC_DELAY),
        .LFSR_SEED  (8'hA5),
        .PL_TIMEOUT (PL_TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start),
        .ship_count_i  (ship_count),
        .fire_i        (fire),
        .cur_i_i       (cur_i),
        .cur_j_i       (cur_j),
        .pc_i_o        (pc_i),
        .pc_j_o        (pc_j),
        .pc_rd_data_i  (pc_rd_data),
        .pc_wr_en_o    (pc_wr_en),
        .pc_wr_data_o  (pc_wr_data),
        .pl_i_o        (pl_i),
        .pl_j_o        (pl_j),
        .pl_rd_data_i  (pl_rd_data),
        .pl_wr_en_o    (pl_wr_en),
        .pl_wr_data_o  (pl_wr_data),
        .turn_o        (turn),
        .shot_valid_o  (shot_valid),
        .shot_hit_o    (shot_hit),
        .player_hits_o (player_hits),
        .pc_hits_o     (pc_hits),
        .victory_o     (victory),
        .defeat_o      (defeat)
    );

    assign pc_rd_data = pc_board[pc_i][pc_j];
    assign pl_rd_data = pl_board[pl_i][pl_j];

    always @(posedge clk) begin
        if (pc_wr_en) begin
            pc_board[pc_i][pc_j] <= pc_wr_data;
            pc_wr_cnt <= pc_wr_cnt + 1;
        end
        if (pl_wr_en) begin
            pl_board[pl_i][pl_j] <= pl_wr_data;
            pl_wr_cnt    <= pl_wr_cnt + 1;
            last_pl_i    <= pl_i;
            last_pl_j    <= pl_j;
            last_pl_prev <= pl_board[pl_i][pl_j];
        end
        if (pc_wr_en && pl_wr_en) begin
            both_wr <= both_wr + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_boards(input logic [1:0] pc_val, input logic [1:0] pl_val);
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                pc_board[i][j] <= pc_val;
                pl_board[i][j] <= pl_val;
            end
        end
    endtask

    task automatic do_reset();
        fire  = 1'b0;
        start = 1'b0;
        rst   = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic start_game(input logic [2:0] n);
        ship_count = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_fire(input logic [2:0] i, input logic [2:0] j);
        cur_i = i;
        cur_j = j;
        fire  = 1'b1;
        tick();
        fire = 1'b0;
    endtask

    // Waits for the PC to take over and hand back; returns the number of turn=1 samples.
    task automatic wait_pc_turn(input string tag, output int cycles);
        int guard;
        cycles = 0;
        guard  = 0;
        while (!turn && guard < 10) begin
            tick();
            guard++;
        end
        if (!turn) check({tag, "_pc_turn_start_timeout"}, 32'd1, 32'd0);
        guard = 0;
        while (turn && guard < 400) begin
            cycles++;
            tick();
            guard++;
        end
        if (turn) check({tag, "_pc_turn_end_timeout"}, 32'd1, 32'd0);
    endtask

    function automatic logic [31:0] all_outputs();
        return {7'd0, pc_wr_en, pl_wr_en, shot_valid, shot_hit, turn, victory, defeat,
                pc_i, pc_j, pl_i, pl_j, player_hits, pc_hits, pc_wr_data, pl_wr_data};
    endfunction

    initial begin
        int base_pc, base_pl, cyc;

        fill_boards(WATER, WATER);
        do_reset();
        check("reset_outputs", all_outputs(), 32'd0);

        // 1: single ship hit wins the game
        fill_boards(WATER, WATER);
        pc_board[2][3] <= SHIP;
        do_reset();
        start_game(3'd1);
        check("t1_turn_p_wait", turn, 1'b0);
        base_pc = pc_wr_cnt;
        pulse_fire(3'd2, 3'd3);
        check("t1_addr", {pc_i, pc_j}, {3'd2, 3'd3});
        check("t1_no_wr_yet", pc_wr_en, 1'b0);
        tick();
        check("t1_wr_en", pc_wr_en, 1'b1);
        check("t1_wr_data", pc_wr_data, 2'b11);
        check("t1_shot", {shot_valid, shot_hit}, 2'b11);
        tick();
        check("t1_victory", victory, 1'b1);
        check("t1_player_hits", player_hits, 3'd1);
        check("t1_board", pc_board[2][3], 2'b11);
        pulse_fire(3'd0, 3'd0);
        tick();
        tick();
        check("t1_fire_after_win", pc_wr_cnt - base_pc, 32'd1);
        check("t1_victory_sticky", {victory, turn}, 2'b10);

        // 2: already-shot cell is ignored, water shot writes MISS
        fill_boards(WATER, WATER);
        pc_board[1][1] <= MISS;
        pc_board[4][4] <= SHIP;
        do_reset();
        start_game(3'd2);
        base_pc = pc_wr_cnt;
        pulse_fire(3'd1, 3'd1);
        check("t2_check_quiet", {pc_wr_en, shot_valid}, 2'b00);
        tick();
        check("t2_back_quiet", {pc_wr_en, shot_valid, turn}, 3'b000);
        pulse_fire(3'd0, 3'd0);
        tick();
        check("t2_wr", {pc_wr_en, pc_wr_data, shot_valid, shot_hit}, {1'b1, 2'b10, 1'b1, 1'b0});
        tick();
        check("t2_turn_pc", turn, 1'b1);
        check("t2_no_extra_wr", pc_wr_cnt - base_pc, 32'd1);
        check("t2_board", pc_board[0][0], 2'b10);

        // 3: PC turn with short delay; a fire during the PC turn is dropped
        base_pl = pl_wr_cnt;
        pulse_fire(3'd3, 3'd3);
        wait_pc_turn("t3", cyc);
        check("t3_turn_len_ge_delay", cyc + 1 >= PC_DELAY, 1'b1);
        check("t3_one_pl_write", pl_wr_cnt - base_pl, 32'd1);
        check("t3_target_range", (last_pl_i < 3'd5) && (last_pl_j < 3'd5), 1'b1);
        check("t3_target_unshot", last_pl_prev[1], 1'b0);
        check("t3_target_miss", pl_board[last_pl_i][last_pl_j], 2'b10);
        tick();
        tick();
        check("t3_dropped_fire", pc_wr_cnt - base_pc, 32'd1);
        pulse_fire(3'd5, 3'd2);
        tick();
        tick();
        check("t3_out_of_range", {pc_wr_cnt - base_pc, 31'd0, turn}, {32'd1, 31'd0, 1'b0});

        // 4: ship_count clamps to 5; defeat when pc_hits reaches 5
        fill_boards(WATER, SHIP);
        do_reset();
        start_game(3'd7);
        base_pc = pc_wr_cnt;
        base_pl = pl_wr_cnt;
        for (int k = 0; k < 5; k++) begin
            pulse_fire(3'd4, 3'(k));
            wait_pc_turn("t4", cyc);
            check($sformatf("t4_pc_hits_r%0d", k), pc_hits, 32'(k + 1));
            check($sformatf("t4_defeat_r%0d", k), defeat, (k == 4) ? 1'b1 : 1'b0);
        end
        pulse_fire(3'd0, 3'd0);
        start_game(3'd1);
        tick();
        check("t4_pc_writes", pc_wr_cnt - base_pc, 32'd5);
        check("t4_pl_writes", pl_wr_cnt - base_pl, 32'd5);
        check("t4_end_state", {defeat, victory, player_hits}, {1'b1, 1'b0, 3'd0});

        // 5: asynchronous reset in the middle of a write
        fill_boards(WATER, WATER);
        pc_board[0][1] <= SHIP;
        do_reset();
        start_game(3'd2);
        pulse_fire(3'd0, 3'd1);
        tick();
        check("t5_in_write", pc_wr_en, 1'b1);
        base_pc = pc_wr_cnt;
        rst = 1'b1;
        #1;
        check("t5_async_zero", all_outputs(), 32'd0);
        tick();
        rst = 1'b0;
        check("t5_cell_kept", pc_board[0][1], 2'b01);
        pulse_fire(3'd0, 3'd1);
        tick();
        tick();
        tick();
        check("t5_no_wr_after_rst", pc_wr_cnt - base_pc, 32'd0);

        // 6: player-turn timeout
        fill_boards(WATER, WATER);
        do_reset();
        base_pc = pc_wr_cnt;
        start_game(3'd1);
        for (int k = 0; k < PL_TIMEOUT - 1; k++) tick();
        check("t6_still_player", turn, 1'b0);
        tick();
`ifdef TURN_TIMEOUT_EN
        check("t6_forfeit_turn", turn, 1'b1);
`else
        check("t6_no_timeout", turn, 1'b0);
        for (int k = 0; k < 20; k++) tick();
        check("t6_no_timeout_late", turn, 1'b0);
`endif
        check("t6_no_pc_write", pc_wr_cnt - base_pc, 32'd0);
        check("never_both_wr", both_wr, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
